character_action_fsm: RTL

Per-character action controller sitting directly downstream of the keyboard decoder: consumes that decoder's level-sensitive move-left / move-right / attack / defense flags and turns them into the character's horizontal position, facing, and action phase. Inputs are sampled and state advances once per video frame on a one-cycle frame strobe. Outputs feed the sprite renderer and the hit-detection logic. The top level instantiates one copy per character; character 1 ties `defense` low.

---
 rtl/fighter_pkg.sv | 27 ++
 rtl/character_action_fsm_if.sv | 34 +++
 rtl/phase_timer.sv | 45 ++++
 rtl/character_action_fsm.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// ============================================================================
// Module : fighter_pkg
// Brief  : Shared action-state encoding, facing constants and widths.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fighter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WALK    = 3'd1,
    ST_DEFEND  = 3'd2,
    ST_WINDUP  = 3'd3,
    ST_ACTIVE  = 3'd4,
    ST_RECOVER = 3'd5
  } action_state_t;

  localparam logic FACE_LEFT  = 1'b0;
  localparam logic FACE_RIGHT = 1'b1;

  localparam int POS_W = 10;
  localparam int TMR_W = 8;

endpackage

`default_nettype wire

// File: rtl/character_action_fsm_if.sv
// ============================================================================
// Module : character_action_fsm_if
// Brief  : Key flags and frame strobe in; position, facing and phase out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface character_action_fsm_if;
  import fighter_pkg::*;

  logic                 frame_tick;
  logic                 move_l;
  logic                 move_r;
  logic                 attack;
  logic                 defense;
  logic [POS_W-1:0]     pos_x;
  logic                 facing;
  action_state_t        state;
  logic                 hit_active;
  logic [2:0]           anim_frame;

  modport master (
    output frame_tick, move_l, move_r, attack, defense,
    input  pos_x, facing, state, hit_active, anim_frame
  );

  modport slave (
    input  frame_tick, move_l, move_r, attack, defense,
    output pos_x, facing, state, hit_active, anim_frame
  );

endinterface

`default_nettype wire

// File: rtl/phase_timer.sv
// ============================================================================
// Module : phase_timer
// Brief  : Loadable per-frame down-counter; done_o flags a count of zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module phase_timer
  import fighter_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (tick_i) begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/character_action_fsm.sv
// ============================================================================
// Module : character_action_fsm
// Brief  : Per-character walk/defend/attack controller, advanced once per frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module character_action_fsm
  import fighter_pkg::*;
#(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 560,
  parameter int X_INIT    = 80,
  parameter int FACE_INIT = 1,
  parameter int STEP      = 2,
  parameter int T_WINDUP  = 4,
  parameter int T_ACTIVE  = 3,
  parameter int T_RECOVER = 6
) (
  input  logic                   Clk,
  input  logic                   Reset,
  character_action_fsm_if.slave  bus_if
);

  localparam int c_ext_w = POS_W + 1;
  localparam logic [TMR_W-1:0] c_ld_windup  = TMR_W'(T_WINDUP - 1);
  localparam logic [TMR_W-1:0] c_ld_active  = TMR_W'(T_ACTIVE - 1);
  localparam logic [TMR_W-1:0] c_ld_recover = TMR_W'(T_RECOVER - 1);
  localparam logic signed [c_ext_w-1:0] c_step = c_ext_w'(STEP);
  localparam logic signed [c_ext_w-1:0] c_xmin = c_ext_w'(X_MIN);
  localparam logic signed [c_ext_w-1:0] c_xmax = c_ext_w'(X_MAX);

  action_state_t      state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               facing_q, facing_d;
  logic               hit_q;
  logic [2:0]         anim_q;
  logic               atk_prev_q;

  logic               w_atk_edge;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_done;
  logic signed [c_ext_w-1:0] w_pos_ext;
  logic signed [c_ext_w-1:0] w_pos_mov;
  logic [POS_W-1:0]   w_pos_sat;

  phase_timer #(.W(TMR_W)) u_phase_timer (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .tick_i     (bus_if.frame_tick),
    .load_i     (w_tmr_load),
    .load_val_i (w_tmr_val),
    .done_o     (w_tmr_done)
  );

  assign w_atk_edge = bus_if.attack & ~atk_prev_q;

  // Signed one-bit-wider step so a move past either edge clamps instead of wrapping
  always_comb begin
    w_pos_ext = signed'({1'b0, pos_q});
    w_pos_mov = bus_if.move_r ? (w_pos_ext + c_step) : (w_pos_ext - c_step);
    if (w_pos_mov > c_xmax) begin
      w_pos_sat = POS_W'(X_MAX);
    end else if (w_pos_mov < c_xmin) begin
      w_pos_sat = POS_W'(X_MIN);
    end else begin
      w_pos_sat = w_pos_mov[POS_W-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    facing_d   = facing_q;
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    unique case (state_q)
      ST_IDLE, ST_WALK, ST_DEFEND: begin
        if (w_atk_edge) begin
          state_d    = ST_WINDUP;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_ld_windup;
        end else if (bus_if.defense) begin
          state_d = ST_DEFEND;
        end else if (bus_if.move_l ^ bus_if.move_r) begin
          state_d  = ST_WALK;
          pos_d    = w_pos_sat;
          facing_d = bus_if.move_r ? FACE_RIGHT : FACE_LEFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WINDUP: begin
        if (w_tmr_done) begin
          state_d    = ST_ACTIVE;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_ld_active;
        end
      end
      ST_ACTIVE: begin
        if (w_tmr_done) begin
          state_d    = ST_RECOVER;
          w_tmr_load = 1'b1;
          w_tmr_val  = c_ld_recover;
        end
      end
      ST_RECOVER: begin
        if (w_tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // attack_prev resets high so a key held through reset cannot fire
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      pos_q      <= POS_W'(X_INIT);
      facing_q   <= FACE_INIT[0];
      hit_q      <= 1'b0;
      anim_q     <= 3'd0;
      atk_prev_q <= 1'b1;
    end else if (bus_if.frame_tick) begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      facing_q   <= facing_d;
      hit_q      <= (state_d == ST_ACTIVE);
      anim_q     <= (state_d != state_q) ? 3'd0 : anim_q + 3'd1;
      atk_prev_q <= bus_if.attack;
    end
  end

  assign bus_if.pos_x      = pos_q;
  assign bus_if.facing     = facing_q;
  assign bus_if.state      = state_q;
  assign bus_if.hit_active = hit_q;
  assign bus_if.anim_frame = anim_q;

endmodule

`default_nettype wire
